// File: rtl/axi_cmd_master.sv
// axi_cmd_master: one-outstanding simple-command to AXI3 INCR burst master (AW/W/B and AR/R sequenced by one FSM).
// Define AXI_CMD_MASTER_PERF_EN to add W/R beat counters and a busy-cycle counter.
module axi_cmd_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [3:0]            cmd_len,
    input  logic [ID_W-1:0]       cmd_id,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [DATA_W-1:0]     wd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_last,
    output logic                  done_valid,
    output logic [1:0]            done_resp,
    output logic                  done_err,
`ifdef AXI_CMD_MASTER_PERF_EN
    output logic [31:0]           wr_beat_cnt,
    output logic [31:0]           rd_beat_cnt,
    output logic [31:0]           busy_cnt,
`endif
    output logic [ADDR_W-1:0]     AWADDR,
    output logic [ID_W-1:0]       AWID,
    output logic [3:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic [3:0]            AWCACHE,
    output logic [2:0]            AWPROT,
    output logic [1:0]            AWLOCK,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_W-1:0]     WDATA,
    output logic [ID_W-1:0]       WID,
    output logic [DATA_W/8-1:0]   WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic [ID_W-1:0]       BID,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_W-1:0]     ARADDR,
    output logic [ID_W-1:0]       ARID,
    output logic [3:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic [3:0]            ARCACHE,
    output logic [2:0]            ARPROT,
    output logic [1:0]            ARLOCK,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_W-1:0]     RDATA,
    input  logic [ID_W-1:0]       RID,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic [2:0]  AXSIZE = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          len_q, len_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [3:0]          beat_q, beat_d;
    logic [1:0]          resp_q, resp_d;
    logic                err_q, err_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                awvalid_q, awvalid_d;
    logic                arvalid_q, arvalid_d;
    logic                bready_q, bready_d;
    logic                done_valid_q, done_valid_d;
    logic [1:0]          done_resp_q, done_resp_d;
    logic                done_err_q, done_err_d;

    logic                st_w, st_r;
    logic                cmd_hs, aw_hs, ar_hs, w_hs, b_hs, r_hs;
    logic                beat_is_last;
    logic                r_beat_err;
    logic [1:0]          r_resp_max;

    assign st_w         = (state_q == ST_W);
    assign st_r         = (state_q == ST_R);
    assign cmd_hs       = cmd_ready_q & cmd_valid;
    assign aw_hs        = awvalid_q & AWREADY;
    assign ar_hs        = arvalid_q & ARREADY;
    assign w_hs         = st_w & wd_valid & WREADY;
    assign b_hs         = bready_q & BVALID;
    assign r_hs         = st_r & RVALID & rd_ready;
    assign beat_is_last = (beat_q == len_q);
    // RLAST must coincide exactly with the final expected beat, and every RID must match.
    assign r_beat_err   = (RID != id_q) | (RLAST != beat_is_last);
    assign r_resp_max   = (RRESP > resp_q) ? RRESP : resp_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        id_d         = id_q;
        beat_d       = beat_q;
        resp_d       = resp_q;
        err_d        = err_q;
        done_valid_d = 1'b0;
        done_resp_d  = done_resp_q;
        done_err_d   = done_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    id_d    = cmd_id;
                    beat_d  = 4'd0;
                    resp_d  = 2'd0;
                    err_d   = 1'b0;
                    state_d = cmd_write ? ST_AW : ST_AR;
                end
            end
            ST_AW: begin
                if (aw_hs) begin
                    state_d = ST_W;
                end
            end
            ST_W: begin
                if (w_hs) begin
                    if (beat_is_last) begin
                        beat_d  = 4'd0;
                        state_d = ST_B;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            ST_B: begin
                if (b_hs) begin
                    done_valid_d = 1'b1;
                    done_resp_d  = BRESP;
                    done_err_d   = (BID != id_q);
                    state_d      = ST_IDLE;
                end
            end
            ST_AR: begin
                if (ar_hs) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (r_hs) begin
                    resp_d = r_resp_max;
                    err_d  = err_q | r_beat_err;
                    // A missing RLAST still ends the burst on the final beat, so the counter never wraps.
                    if (RLAST || beat_is_last) begin
                        done_valid_d = 1'b1;
                        done_resp_d  = r_resp_max;
                        done_err_d   = err_q | r_beat_err;
                        beat_d       = 4'd0;
                        state_d      = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        awvalid_d   = (state_d == ST_AW);
        arvalid_d   = (state_d == ST_AR);
        bready_d    = (state_d == ST_B);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            id_q         <= '0;
            beat_q       <= '0;
            resp_q       <= '0;
            err_q        <= 1'b0;
            cmd_ready_q  <= 1'b0;
            awvalid_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            done_valid_q <= 1'b0;
            done_resp_q  <= '0;
            done_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            id_q         <= id_d;
            beat_q       <= beat_d;
            resp_q       <= resp_d;
            err_q        <= err_d;
            cmd_ready_q  <= cmd_ready_d;
            awvalid_q    <= awvalid_d;
            arvalid_q    <= arvalid_d;
            bready_q     <= bready_d;
            done_valid_q <= done_valid_d;
            done_resp_q  <= done_resp_d;
            done_err_q   <= done_err_d;
        end
    end

`ifdef AXI_CMD_MASTER_PERF_EN
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] busy_q, busy_d;

    // Saturating performance counters.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        busy_d   = busy_q;
        if (w_hs && (wr_cnt_q != 32'hFFFF_FFFF)) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
        if (r_hs && (rd_cnt_q != 32'hFFFF_FFFF)) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
        if ((state_q != ST_IDLE) && (busy_q != 32'hFFFF_FFFF)) begin
            busy_d = busy_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            busy_q   <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign wr_beat_cnt = wr_cnt_q;
    assign rd_beat_cnt = rd_cnt_q;
    assign busy_cnt    = busy_q;
`endif

    assign cmd_ready  = cmd_ready_q;
    assign done_valid = done_valid_q;
    assign done_resp  = done_resp_q;
    assign done_err   = done_err_q;

    // Address channels: payload is only driven while the request is pending.
    assign AWVALID = awvalid_q;
    assign AWADDR  = awvalid_q ? addr_q : '0;
    assign AWID    = awvalid_q ? id_q : '0;
    assign AWLEN   = awvalid_q ? len_q : '0;
    assign AWSIZE  = AXSIZE;
    assign AWBURST = 2'b01;
    assign AWCACHE = 4'd0;
    assign AWPROT  = 3'd0;
    assign AWLOCK  = 2'd0;

    assign ARVALID = arvalid_q;
    assign ARADDR  = arvalid_q ? addr_q : '0;
    assign ARID    = arvalid_q ? id_q : '0;
    assign ARLEN   = arvalid_q ? len_q : '0;
    assign ARSIZE  = AXSIZE;
    assign ARBURST = 2'b01;
    assign ARCACHE = 4'd0;
    assign ARPROT  = 3'd0;
    assign ARLOCK  = 2'd0;

    // Write data streams straight through while in the W phase.
    assign WVALID   = st_w & wd_valid;
    assign wd_ready = st_w & WREADY;
    assign WDATA    = st_w ? wd_data : '0;
    assign WID      = st_w ? id_q : '0;
    assign WSTRB    = {STRB_W{1'b1}};
    assign WLAST    = st_w & beat_is_last;
    assign BREADY   = bready_q;

    // Read data streams straight through while in the R phase.
    assign RREADY   = st_r & rd_ready;
    assign rd_valid = st_r & RVALID;
    assign rd_data  = st_r ? RDATA : '0;
    assign rd_last  = st_r & RLAST;

endmodule
